aes_decrypt: RTL and testbench

Iterative AES-128 decryption core, the inverse counterpart of the team's iterative AES-128 encryption core in the Pass-Keeper AES datapath. It accepts a 128-bit ciphertext and the 128-bit cipher key on a `start` pulse. It first expands the key forward to round key 10, then performs one inverse round per clock while walking the key schedule backwards on the fly. The recovered plaintext is presented with a one-cycle `ready` pulse.

---
 rtl/aes_decrypt.sv | 211 +++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryption core: forward key expansion to round key 10,
// then one inverse round per clock while stepping the key schedule backwards.
module aes_decrypt (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic [127:0] plain_text,
    output logic         ready,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ADDKEY, ROUND} state_t;

    state_t       state, state_next;
    logic [3:0]   rnd;
    logic [127:0] ct_reg, k0_reg, key_reg, st;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box: inverse followed by the affine transform
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by the field inverse
    function automatic logic [7:0] sbox_inv(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i sits at [127-8i -: 8]; state element (row r, col c) is byte r+4c
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c      -: 8];
            a1 = s[127-32*c-8    -: 8];
            a2 = s[127-32*c-16   -: 8];
            a3 = s[127-32*c-24   -: 8];
            o[127-32*c    -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
            o[127-32*c-8  -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
            o[127-32*c-16 -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
            o[127-32*c-24 -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
        end
        return o;
    endfunction

    // Key schedule words, w0 is the most significant
    logic [31:0] w0, w1, w2, w3;
    assign {w0, w1, w2, w3} = key_reg;

    // The four forward S-boxes are shared: KEYEXP substitutes w3, ROUND
    // substitutes the recovered previous w3 (w3^w2).
    logic [31:0] sub_in, sub_rot, sub_out;
    logic [3:0]  rc_idx;
    logic [31:0] rc_word;
    assign sub_in  = (state == KEYEXP) ? w3 : (w3 ^ w2);
    assign sub_rot = {sub_in[23:0], sub_in[31:24]};
    assign rc_idx  = (state == KEYEXP) ? rnd : rnd + 4'd1;
    assign rc_word = {rcon(rc_idx), 24'h000000};

    for (genvar i = 0; i < 4; i++) begin : g_fsbox
        assign sub_out[8*i +: 8] = sbox_fwd(sub_rot[8*i +: 8]);
    end

    // Forward step (next round key) and inverse step (previous round key)
    logic [31:0]  fw0, fw1, fw2, fw3;
    logic [127:0] fk, nk;
    assign fw0 = w0 ^ sub_out ^ rc_word;
    assign fw1 = w1 ^ fw0;
    assign fw2 = w2 ^ fw1;
    assign fw3 = w3 ^ fw2;
    assign fk  = {fw0, fw1, fw2, fw3};
    assign nk  = {w0 ^ sub_out ^ rc_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    // Inverse round datapath: 16 inverse S-boxes after InvShiftRows
    logic [127:0] sr, sb, ark, imc;
    assign sr = inv_shift_rows(st);

    for (genvar i = 0; i < 16; i++) begin : g_isbox
        assign sb[8*i +: 8] = sbox_inv(sr[8*i +: 8]);
    end

    assign ark = sb ^ nk;
    assign imc = inv_mix_columns(ark);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = KEYEXP;
            KEYEXP:  if (rnd == 4'd10) state_next = ADDKEY;
            ADDKEY:  state_next = ROUND;
            ROUND:   if (rnd == 4'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, round counter and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd        <= 4'd0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            plain_text <= '0;
            ct_reg     <= '0;
            k0_reg     <= '0;
            key_reg    <= '0;
            st         <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ct_reg  <= ciphertext;
                        k0_reg  <= key;
                        key_reg <= key;
                        busy    <= 1'b1;
                        rnd     <= 4'd1;
                    end
                end
                KEYEXP: begin
                    key_reg <= fk;
                    rnd     <= rnd + 4'd1;
                end
                ADDKEY: begin
                    st  <= ct_reg ^ key_reg;
                    rnd <= 4'd9;
                end
                ROUND: begin
                    if (rnd == 4'd0) begin
                        // The walked-back key equals the captured cipher key
                        // here, so the stored copy closes the last round.
                        plain_text <= sb ^ k0_reg;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        st      <= imc;
                        key_reg <= nk;
                        rnd     <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt: stimulus pushes expected plaintext and
// completion cycle; a monitor pops and compares on every ready pulse.
module tb_aes_decrypt;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] ciphertext, key, plain_text;
    logic         ready, busy;

    int cyc    = 0;
    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C3  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] K4  = 128'h0;
    localparam logic [127:0] C4  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] P4  = 128'h0;

    aes_decrypt dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .plain_text (plain_text),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one start pulse; called at a falling edge
    task automatic issue(input logic [127:0] k, input logic [127:0] c,
                         input logic [127:0] p, input bit expect_it);
        start      = 1'b1;
        key        = k;
        ciphertext = c;
        if (expect_it) sb_q.push_back('{p, cyc + 22});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Bounded wait for all outstanding results
    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check_int("drain_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: compare every ready pulse against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready) begin
                check("ready_vs_busy", {127'b0, busy}, 128'h0);
                if (sb_q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_ready: got ready=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("plain_text", plain_text, e.pt);
                    check_int("ready_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        int c0;
        reset      = 1'b1;
        start      = 1'b0;
        key        = '0;
        ciphertext = '0;
        repeat (3) @(negedge clk);
        check("rst_plain", plain_text, 128'h0);
        check("rst_ready", {127'b0, ready}, 128'h0);
        check("rst_busy",  {127'b0, busy},  128'h0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1
        issue(K1, C1, P1, 1'b1);
        check("busy_after_start", {127'b0, busy}, 128'h1);
        drain();

        // FIPS-197 B, with round key 10 observed after key expansion
        c0 = cyc;
        issue(K2, C2, P2, 1'b1);
        wait_cyc(c0 + 12);
        check("round_key_10", dut.key_reg, RK2);
        drain();

        // Starts while busy are ignored
        c0 = cyc;
        issue(K1, C1, P1, 1'b1);
        wait_cyc(c0 + 5);
        issue(K2, C2, P2, 1'b0);
        wait_cyc(c0 + 15);
        issue(K2, C3, P3, 1'b0);
        drain();
        repeat (25) @(negedge clk);

        // Back-to-back with start held high, inputs switched in the ready cycle
        c0         = cyc;
        start      = 1'b1;
        key        = K2;
        ciphertext = C3;
        sb_q.push_back('{P3, c0 + 22});
        wait_cyc(c0 + 22);
        key        = K1;
        ciphertext = C1;
        sb_q.push_back('{P1, c0 + 44});
        wait_cyc(c0 + 44);
        start = 1'b0;
        drain();

        // Reset mid-operation aborts the block
        c0 = cyc;
        issue(K2, C2, P2, 1'b1);
        wait_cyc(c0 + 12);
        reset = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",  {127'b0, busy},  128'h0);
        check("abort_ready", {127'b0, ready}, 128'h0);
        check("abort_plain", plain_text, 128'h0);
        repeat (30) @(negedge clk);
        issue(K4, C4, P4, 1'b1);
        drain();
        issue(K1, C1, P1, 1'b1);
        drain();

        // Reset wins over a simultaneous start
        start      = 1'b1;
        reset      = 1'b1;
        key        = K2;
        ciphertext = C2;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_start_busy", {127'b0, busy}, 128'h0);
        @(negedge clk);
        check("rst_start_idle", {127'b0, busy}, 128'h0);
        repeat (25) @(negedge clk);

        // Final vector after the reset sequence
        issue(K2, C2, P2, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
